// File: rtl/down_timer_ctrl.sv
// rtl/down_timer_ctrl.sv - programmable countdown timer with prescaler, pause and terminal pulse
module down_timer_ctrl #(
   parameter int WIDTH    = 4,
   parameter int PRESCALE = 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic             stop_i,
   input  logic             pause_i,
   input  logic             auto_reload_i,
   input  logic [WIDTH-1:0] load_val_i,
   output logic [WIDTH-1:0] count_o,
   output logic             busy_o,
   output logic             done_o
);

   localparam int PW = $clog2(PRESCALE) + 1;
   localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      PAUSED
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic [WIDTH-1:0] reload_q, reload_d;
   logic             mode_q, mode_d;
   logic [PW-1:0]    pre_q, pre_d;
   logic             done_q, done_d;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         count_q  <= '0;
         reload_q <= '0;
         mode_q   <= 1'b0;
         pre_q    <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         reload_q <= reload_d;
         mode_q   <= mode_d;
         pre_q    <= pre_d;
         done_q   <= done_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      reload_d = reload_q;
      mode_d   = mode_q;
      pre_d    = pre_q;
      done_d   = 1'b0;

      if (stop_i) begin
         if (state_q != IDLE) begin
            state_d = IDLE;
            pre_d   = '0;
         end
      end else if (start_i && (state_q == IDLE)) begin
         if (load_val_i != '0) begin
            count_d  = load_val_i;
            reload_d = load_val_i;
            mode_d   = auto_reload_i;
            pre_d    = '0;
            state_d  = RUN;
         end else begin
            count_d = '0;
            done_d  = 1'b1;
         end
      end else if (state_q != IDLE) begin
         // The edge that releases pause already counts as a running cycle,
         // so a pause of m sampled edges costs exactly m cycles.
         if (pause_i) begin
            state_d = PAUSED;
         end else begin
            state_d = RUN;
            if (pre_q == PRE_MAX) begin
               pre_d = '0;
               if (count_q > WIDTH'(1)) begin
                  count_d = count_q - WIDTH'(1);
               end else if (mode_q) begin
                  count_d = reload_q;
                  done_d  = 1'b1;
               end else begin
                  count_d = '0;
                  done_d  = 1'b1;
                  state_d = IDLE;
               end
            end else begin
               pre_d = pre_q + PW'(1);
            end
         end
      end
   end

   assign count_o = count_q;
   assign busy_o  = (state_q != IDLE);
   assign done_o  = done_q;

endmodule

// File: tb/tb_down_timer_ctrl.sv
// tb/tb_down_timer_ctrl.sv - directed self-checking bench for down_timer_ctrl
module tb_down_timer_ctrl;

   logic       clk = 1'b0;
   logic       rst, start, stop, pause, auto_reload;
   logic [3:0] load_val;
   logic [3:0] count1, count4;
   logic       busy1, busy4, done1, done4;
   int         checks = 0;
   int         failures = 0;

   always #5 clk = ~clk;

   down_timer_ctrl #(.WIDTH(4), .PRESCALE(1)) dut_p1 (
      .clk_i(clk), .rst_i(rst), .start_i(start), .stop_i(stop), .pause_i(pause),
      .auto_reload_i(auto_reload), .load_val_i(load_val),
      .count_o(count1), .busy_o(busy1), .done_o(done1)
   );

   down_timer_ctrl #(.WIDTH(4), .PRESCALE(4)) dut_p4 (
      .clk_i(clk), .rst_i(rst), .start_i(start), .stop_i(stop), .pause_i(pause),
      .auto_reload_i(auto_reload), .load_val_i(load_val),
      .count_o(count4), .busy_o(busy4), .done_o(done4)
   );

   task automatic tick_n(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0;
      auto_reload = 1'b0; load_val = 4'd0;
      tick_n(1);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b1; stop = 1'b0; pause = 1'b0;
      auto_reload = 1'b0; load_val = 4'd5;
      tick_n(2);
      checks++;
      if (count1 !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count1); end
      checks++;
      if (busy1 !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy1); end
      checks++;
      if (done1 !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b exp=0", done1); end
      rst = 1'b0; start = 1'b0;
      tick_n(1);
      checks++;
      if (busy1 !== 1'b0 || count1 !== 4'd0) begin
         failures++; $display("FAIL reset_start_ignored busy=%0b count=%0d exp busy=0 count=0", busy1, count1);
      end
   endtask

   task automatic test_oneshot();
      logic [3:0] exp_cnt [6] = '{4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0};
      do_reset();
      load_val = 4'd5; auto_reload = 1'b0; start = 1'b1;
      tick_n(1);
      start = 1'b0;
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (count1 !== exp_cnt[i] || busy1 !== (i < 5) || done1 !== (i == 5)) begin
            failures++;
            $display("FAIL oneshot[%0d] count=%0d busy=%0b done=%0b exp count=%0d busy=%0b done=%0b",
                     i, count1, busy1, done1, exp_cnt[i], (i < 5), (i == 5));
         end
         if (i == 2) begin start = 1'b1; load_val = 4'd9; end
         if (i == 3) begin start = 1'b0; load_val = 4'd5; end
         tick_n(1);
      end
      checks++;
      if (done1 !== 1'b0 || count1 !== 4'd0 || busy1 !== 1'b0) begin
         failures++; $display("FAIL oneshot_after done=%0b count=%0d busy=%0b exp 0 0 0", done1, count1, busy1);
      end
   endtask

   task automatic test_periodic();
      logic [3:0] exp_cnt [7] = '{4'd3, 4'd2, 4'd1, 4'd3, 4'd2, 4'd1, 4'd3};
      do_reset();
      load_val = 4'd3; auto_reload = 1'b1; start = 1'b1;
      tick_n(1);
      start = 1'b0; auto_reload = 1'b0;
      for (int i = 0; i < 7; i++) begin
         if (i > 0) tick_n(1);
         checks++;
         if (count1 !== exp_cnt[i] || busy1 !== 1'b1 || done1 !== (i == 3 || i == 6)) begin
            failures++;
            $display("FAIL periodic[%0d] count=%0d busy=%0b done=%0b exp count=%0d busy=1 done=%0b",
                     i, count1, busy1, done1, exp_cnt[i], (i == 3 || i == 6));
         end
      end
      tick_n(1);
      checks++;
      if (count1 !== 4'd2) begin failures++; $display("FAIL periodic_pre_stop got=%0d exp=2", count1); end
      stop = 1'b1;
      tick_n(1);
      stop = 1'b0;
      checks++;
      if (count1 !== 4'd2 || busy1 !== 1'b0 || done1 !== 1'b0) begin
         failures++; $display("FAIL periodic_stop count=%0d busy=%0b done=%0b exp 2 0 0", count1, busy1, done1);
      end
      tick_n(3);
      checks++;
      if (count1 !== 4'd2 || done1 !== 1'b0) begin
         failures++; $display("FAIL periodic_stop_hold count=%0d done=%0b exp 2 0", count1, done1);
      end
   endtask

   task automatic test_prescale();
      do_reset();
      load_val = 4'd2; start = 1'b1;
      tick_n(1);
      start = 1'b0;
      for (int j = 0; j <= 8; j++) begin
         if (j > 0) tick_n(1);
         checks++;
         if (count4 !== ((j < 4) ? 4'd2 : (j < 8) ? 4'd1 : 4'd0) || busy4 !== (j < 8) || done4 !== (j == 8)) begin
            failures++;
            $display("FAIL prescale[%0d] count=%0d busy=%0b done=%0b exp count=%0d busy=%0b done=%0b",
                     j, count4, busy4, done4, ((j < 4) ? 2 : (j < 8) ? 1 : 0), (j < 8), (j == 8));
         end
      end
      tick_n(1);
      checks++;
      if (done4 !== 1'b0) begin failures++; $display("FAIL prescale_done_clear got=%0b exp=0", done4); end
   endtask

   task automatic test_pause();
      logic [3:0] exp_cnt [10] = '{4'd6, 4'd5, 4'd4, 4'd4, 4'd4, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0};
      do_reset();
      load_val = 4'd6; start = 1'b1;
      tick_n(1);
      start = 1'b0;
      for (int j = 0; j < 10; j++) begin
         checks++;
         if (count1 !== exp_cnt[j] || busy1 !== (j < 9) || done1 !== (j == 9)) begin
            failures++;
            $display("FAIL pause[%0d] count=%0d busy=%0b done=%0b exp count=%0d busy=%0b done=%0b",
                     j, count1, busy1, done1, exp_cnt[j], (j < 9), (j == 9));
         end
         if (j == 2) pause = 1'b1;
         if (j == 5) pause = 1'b0;
         tick_n(1);
      end
   endtask

   task automatic test_zero_load();
      do_reset();
      load_val = 4'd0; start = 1'b1;
      tick_n(1);
      start = 1'b0;
      checks++;
      if (done1 !== 1'b1 || busy1 !== 1'b0 || count1 !== 4'd0) begin
         failures++; $display("FAIL zero_load done=%0b busy=%0b count=%0d exp 1 0 0", done1, busy1, count1);
      end
      tick_n(1);
      checks++;
      if (done1 !== 1'b0 || busy1 !== 1'b0) begin
         failures++; $display("FAIL zero_load_after done=%0b busy=%0b exp 0 0", done1, busy1);
      end
   endtask

   task automatic test_rst_midrun();
      do_reset();
      load_val = 4'd5; start = 1'b1;
      tick_n(1);
      start = 1'b0;
      tick_n(3);
      checks++;
      if (count1 !== 4'd2) begin failures++; $display("FAIL midrun_pre got=%0d exp=2", count1); end
      rst = 1'b1;
      tick_n(1);
      rst = 1'b0;
      checks++;
      if (count1 !== 4'd0 || busy1 !== 1'b0 || done1 !== 1'b0) begin
         failures++; $display("FAIL midrun_rst count=%0d busy=%0b done=%0b exp 0 0 0", count1, busy1, done1);
      end
      for (int j = 0; j < 4; j++) begin
         tick_n(1);
         checks++;
         if (done1 !== 1'b0 || busy1 !== 1'b0) begin
            failures++; $display("FAIL midrun_quiet[%0d] done=%0b busy=%0b exp 0 0", j, done1, busy1);
         end
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0;
      auto_reload = 1'b0; load_val = 4'd0;
      test_reset();
      test_oneshot();
      test_periodic();
      test_prescale();
      test_pause();
      test_zero_load();
      test_rst_midrun();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/down_timer_ctrl.md
# down_timer_ctrl

Programmable countdown timer that sits directly upstream of the 4-bit down counter stage. It adds load, start/stop/pause control, a clock prescaler and a terminal-count pulse around the decrementing count. The terminal pulse feeds downstream consumers such as interrupt or sequencing logic, and the live count stays visible for display and monitoring.

## Interface
- WIDTH, 4: count width in bits (≥2).
- PRESCALE, 1: clocks per decrement (≥1); internal prescaler is $clog2(PRESCALE)+1 bits.
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request: load load_val and begin counting.
- stop  input  1  abort the current run; count frozen, no done.
- pause  input  1  level; while high in RUN, counting is suspended.
- auto_reload  input  1  sampled at start; 1 = periodic mode.
- load_val  input  WIDTH  start value N, latched at start.
- count  output  WIDTH  current count value (registered).
- busy  output  1  high in RUN or PAUSED.
- done  output  1  one-cycle terminal-count pulse (registered).

## Operation
- States: IDLE, RUN, PAUSED.
- Registers: count, reload_reg (latched N), mode bit (latched auto_reload), prescaler.
- Priority per edge: rst > stop > start > pause > tick.
- Reset values: state IDLE, count 0, busy 0, done 0, prescaler 0, reload_reg 0, mode 0.
- IDLE:
  - start=1 with N≠0: count←N, reload_reg←N, mode←auto_reload, prescaler←0, go to RUN.
  - start=1 with N=0: count←0, done pulses next cycle, stay in IDLE.
- RUN:
  - pause=1: go to PAUSED; prescaler and count hold.
  - Otherwise prescaler increments each cycle.
  - Tick: the prescaler is at PRESCALE−1 (every cycle when PRESCALE=1). On a tick the prescaler wraps to 0 and one of these applies:
    - count>1: count←count−1.
    - count==1, mode=0: count←0, done←1, go to IDLE.
    - count==1, mode=1: count←reload_reg, done←1, stay in RUN. Count never shows 0 in periodic mode.
- PAUSED:
  - pause=0: return to RUN; the prescaler resumes from its held value.
  - No ticks occur while PAUSED.
- stop in RUN or PAUSED: go to IDLE; count holds its current value; no done; prescaler←0.
- start while busy is ignored (no reload); stop in IDLE has no effect.
- done is high only on the single cycle after a terminal tick; otherwise 0.
- Arithmetic is unsigned, modulo 2^WIDTH; count never decrements below 0.

## Timing
- The start sampled at edge k gives count=N and busy=1 after edge k.
- With PRESCALE=P and no pause, decrements occur at edges k+P, k+2P, …
- Terminal tick lands at edge k+N·P.
- One-shot mode: after edge k+N·P, done=1, count=0 and busy=0 in the same cycle; done clears at the next edge.
- Periodic mode: done pulses every N·P cycles, aligned with count=N reappearing.
- Pause cost: pause high for m sampled edges delays every subsequent event by m cycles.
- rst mid-run: the next cycle shows all reset values, and no done is emitted for the aborted run.

## Test plan
- Reset: hold rst for 2 cycles with start=1 → count=0, busy=0, done=0; start ignored.
- One-shot, WIDTH=4, P=1, N=5: pulse start → count 5,4,3,2,1,0 on consecutive cycles; done single cycle coincident with count=0 and busy falling; start while busy (at count 3) has no effect.
- Periodic, N=3, auto_reload=1 → count 3,2,1,3,2,1,3…; done high with each reappearance of 3, every 3 cycles; stop at count 2 → IDLE, count holds 2, no done.
- Prescale, P=4, N=2 → each value held 4 cycles; done exactly 8 cycles after the start edge.
- Pause, P=1, N=6: pause high for 3 cycles at count 4 → count holds 4 for 4 cycles total; done 3 cycles later than the unpaused run.
- Corners: start with N=0 → done pulses once, busy stays 0; rst asserted at count 2 mid-run → all outputs at reset values next cycle, no done.
